// File: rtl/mem_read_if.sv
// mem_read_if -- bundle of the request, BRAM read and systolic-lane signals of
// mem_read.
//
// Parameters mirror the design: D_W data width, N banks/lanes, M matrix
// dimension. Each bank holds D = (M*M)/N words addressed with AW bits.
//
// Signals:
//   start         request to stream the whole matrix (sampled in IDLE only)
//   rd_data_bram  per-bank read data, one cycle after its read enable
//   rd_addr_bram  per-bank registered read address
//   rd_en_bram    per-bank registered read enable
//   out_valid     per-lane valid towards the systolic array
//   out_data      per-lane data, meaningful when the matching out_valid is 1
//   busy          transfer in progress
//   done          one-cycle pulse after the last word of the last lane
//
// Modports: master = the mem_read block, slave = banks plus requester.
interface mem_read_if #(
  parameter int D_W = 8,
  parameter int N   = 3,
  parameter int M   = 6
);
  localparam int D  = (M * M) / N;
  localparam int AW = (D > 1) ? $clog2(D) : 1;

  logic           start;
  logic [D_W-1:0] rd_data_bram [N];
  logic [AW-1:0]  rd_addr_bram [N];
  logic [N-1:0]   rd_en_bram;
  logic [N-1:0]   out_valid;
  logic [D_W-1:0] out_data [N];
  logic           busy;
  logic           done;

  modport master (
    input  start, rd_data_bram,
    output rd_addr_bram, rd_en_bram, out_valid, out_data, busy, done
  );

  modport slave (
    output start, rd_data_bram,
    input  rd_addr_bram, rd_en_bram, out_valid, out_data, busy, done
  );
endinterface

// File: rtl/mem_read.sv
// mem_read -- streams an M x M matrix out of N BRAM banks into N lanes of a
// systolic array. Each bank is read at addresses 0..D-1 exactly once per
// transfer; lane data is the raw BRAM output qualified by a delayed enable.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   mem_read_if.master (start, rd_data_bram in; rd_addr_bram,
//         rd_en_bram, out_valid, out_data, busy, done out)
//
// Optional feature: define MEM_READ_SKEW_EN to delay lane x by x cycles so
// the lanes form a diagonal wavefront. Without it all lanes run in lockstep.
module mem_read #(
  parameter int D_W = 8,
  parameter int N   = 3,
  parameter int M   = 6
) (
  input  logic        clk,
  input  logic        rst,
  mem_read_if.master  bus
);

  localparam int D  = (M * M) / N;
  localparam int AW = (D > 1) ? $clog2(D) : 1;

`ifdef MEM_READ_SKEW_EN
  localparam bit SkewEn = 1'b1;
`else
  localparam bit SkewEn = 1'b0;
`endif

  // Cycle index (relative to the first read cycle) of the last lane's final
  // read; the counter must also reach LAST+1 for the drain cycle.
  localparam int LAST = SkewEn ? (N - 1) + D - 1 : D - 1;
  localparam int CW   = $clog2(LAST + 2);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [N-1:0]   rd_en_q, rd_en_d;
  logic [N-1:0]   valid_q;
  logic [AW-1:0]  addr_q [N];
  logic [AW-1:0]  addr_d [N];
  logic           run;

  function automatic int skewOf(input int lane);
    return SkewEn ? lane : 0;
  endfunction

  // Next-state logic. cnt_d is the index of the cycle about to start, so the
  // per-lane enables and addresses are derived from it and land registered.
  // A start arriving while done is pulsing is ignored, so the earliest new
  // transfer begins the cycle after done.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    run     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !done_q) begin
          state_d = READ;
          cnt_d   = '0;
          busy_d  = 1'b1;
          run     = 1'b1;
        end
      end
      READ: begin
        cnt_d = cnt_q + CW'(1);
        run   = 1'b1;
        if (cnt_q == CW'(LAST)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    for (int x = 0; x < N; x++) begin
      rd_en_d[x] = run && (int'(cnt_d) >= skewOf(x)) &&
                   (int'(cnt_d) <= skewOf(x) + D - 1);
      addr_d[x]  = rd_en_d[x] ? AW'(int'(cnt_d) - skewOf(x)) : '0;
    end
  end

  // State and every output register. out_valid trails the read enable by the
  // one-cycle BRAM latency; reset clears everything so an aborted transfer
  // leaves no trailing valids and no done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= '0;
      valid_q <= '0;
      for (int x = 0; x < N; x++) begin
        addr_q[x] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_en_q <= rd_en_d;
      valid_q <= rd_en_q;
      for (int x = 0; x < N; x++) begin
        addr_q[x] <= addr_d[x];
      end
    end
  end

  assign bus.rd_en_bram   = rd_en_q;
  assign bus.rd_addr_bram = addr_q;
  assign bus.out_valid    = valid_q;
  assign bus.out_data     = bus.rd_data_bram;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_mem_read.sv
// tb_mem_read -- scoreboard bench for mem_read. Every accepted start pushes
// the full cycle-tagged list of expected events (reads, lane valids with
// data, busy cycles, done) into a queue; the monitor pops the events due in
// each cycle and compares them with what the DUT presents.
module tb_mem_read;

  localparam int D_W = 8;
  localparam int N   = 3;
  localparam int M   = 6;
  localparam int D   = (M * M) / N;

`ifdef MEM_READ_SKEW_EN
  localparam int SKEW = 1;
`else
  localparam int SKEW = 0;
`endif

  localparam int EV_BUSY  = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_READ  = 2;
  localparam int EV_VALID = 3;

  typedef struct {
    int cyc;
    int kind;
    int lane;
    int val;
  } ev_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  int   freeAt;
  ev_t  sbQ[$];

  mem_read_if #(.D_W(D_W), .N(N), .M(M)) bus ();

  mem_read #(.D_W(D_W), .N(N), .M(M)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock; cycle c is the period after the c-th rising edge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = -1;
  always @(posedge clk) cyc <= cyc + 1;

  // Bank model: bank x holds 16*x+k at address k, one cycle read latency.
  always @(posedge clk) begin
    for (int x = 0; x < N; x++) begin
      if (bus.rd_en_bram[x]) begin
        bus.rd_data_bram[x] <= D_W'(16 * x + int'(bus.rd_addr_bram[x]));
      end
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic void pushEv(input int c, input int kind, input int lane, input int val);
    ev_t e;
    e.cyc  = c;
    e.kind = kind;
    e.lane = lane;
    e.val  = val;
    sbQ.push_back(e);
  endfunction

  // Expected behaviour of one transfer accepted in cycle t: lane x reads
  // address k in cycle t+1+skew*x+k, shows that word one cycle later, busy
  // covers everything up to the last valid and done follows it.
  task automatic issueTransfer(input int t);
    int lastValid;
    lastValid = 0;
    for (int x = 0; x < N; x++) begin
      if (t + 2 + SKEW * x + D - 1 > lastValid) lastValid = t + 2 + SKEW * x + D - 1;
    end
    for (int c = t + 1; c <= lastValid + 1; c++) begin
      if (c <= lastValid) pushEv(c, EV_BUSY, 0, 1);
      else pushEv(c, EV_DONE, 0, 1);
      for (int x = 0; x < N; x++) begin
        int k;
        k = c - t - 1 - SKEW * x;
        if (k >= 0 && k < D) pushEv(c, EV_READ, x, k);
        k = c - t - 2 - SKEW * x;
        if (k >= 0 && k < D) pushEv(c, EV_VALID, x, 16 * x + k);
      end
    end
    freeAt = lastValid + 2;
  endtask

  // Drives one cycle of inputs and updates the reference model: reset drops
  // everything expected after this cycle; a start counts only once the
  // previous transfer's done cycle has passed.
  task automatic applyStimulus(input logic s, input logic r);
    @(posedge clk);
    #1;
    bus.start = s;
    rst       = r;
    if (r) begin
      while (sbQ.size() > 0 && sbQ[sbQ.size() - 1].cyc > cyc) void'(sbQ.pop_back());
      freeAt = cyc + 1;
    end else if (s && cyc >= freeAt) begin
      issueTransfer(cyc);
    end
  endtask

  // Monitor: gather the events due this cycle and compare the full output
  // picture, including the absence of reads, valids, busy or done.
  logic [N-1:0] eEn, eVal;
  logic         eBusy, eDone, prevRst;
  int           eAddr [N];
  int           eData [N];
  ev_t          ev;

  always @(negedge clk) begin
    if (cyc >= 1) begin
      eEn = '0; eVal = '0; eBusy = 1'b0; eDone = 1'b0;
      for (int x = 0; x < N; x++) begin
        eAddr[x] = 0;
        eData[x] = 0;
      end
      while (sbQ.size() > 0 && sbQ[0].cyc <= cyc) begin
        ev = sbQ.pop_front();
        case (ev.kind)
          EV_BUSY:  eBusy = 1'b1;
          EV_DONE:  eDone = 1'b1;
          EV_READ:  begin eEn[ev.lane] = 1'b1; eAddr[ev.lane] = ev.val; end
          default:  begin eVal[ev.lane] = 1'b1; eData[ev.lane] = ev.val; end
        endcase
      end
      checkOutput("rd_en_bram", int'(bus.rd_en_bram), int'(eEn));
      checkOutput("out_valid", int'(bus.out_valid), int'(eVal));
      checkOutput("busy", int'(bus.busy), int'(eBusy));
      checkOutput("done", int'(bus.done), int'(eDone));
      for (int x = 0; x < N; x++) begin
        if (eEn[x]) checkOutput($sformatf("rd_addr_bram[%0d]", x), int'(bus.rd_addr_bram[x]), eAddr[x]);
        if (eVal[x]) checkOutput($sformatf("out_data[%0d]", x), int'(bus.out_data[x]), eData[x]);
        if (prevRst) checkOutput($sformatf("reset addr[%0d]", x), int'(bus.rd_addr_bram[x]), 0);
      end
    end
    prevRst = rst;
  end

  initial begin
    checks    = 0;
    errors    = 0;
    freeAt    = 0;
    prevRst   = 1'b0;
    rst       = 1'b1;
    bus.start = 1'b0;
    for (int x = 0; x < N; x++) bus.rd_data_bram[x] = '0;

    repeat (3) applyStimulus(1'b0, 1'b1);
    repeat (2) applyStimulus(1'b0, 1'b0);

    $display("[TB] transfer with re-pulsed starts");
    for (int i = 0; i <= 40; i++) applyStimulus(i == 0 || i == 5 || i == 16 || i == 17, 1'b0);

    $display("[TB] reset in the middle of a transfer");
    for (int i = 0; i <= 30; i++) applyStimulus(i == 0 || i == 9, i == 7);

    $display("[TB] reset and start together while idle");
    applyStimulus(1'b1, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b0);

    $display("[TB] back-to-back transfers");
    repeat (60) applyStimulus(1'b1, 1'b0);

    $display("[TB] random starts and resets");
    repeat (400) applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0);

    for (int i = 0; i < 60 && sbQ.size() > 0; i++) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("pending events after drain", sbQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_read.md
MEM_READ -- requirements
Module: mem_read

Interface
REQ-001 Parameter D_W, default 8: data word width in bits.
REQ-002 Parameter N, default 3: number of BRAM banks and output lanes.
REQ-003 Parameter M, default 6: matrix dimension; each bank holds D = (M*M)/N words; AW = $clog2(D).
REQ-004 clk  input  1: single clock; all logic on its rising edge.
REQ-005 rst  input  1: synchronous, active-high reset.
REQ-006 start  input  1: one-cycle request to stream the full matrix out of the banks.
REQ-007 rd_data_bram  input  [D_W-1:0] x N (unpacked): read data returned by each bank, one cycle after its read enable.
REQ-008 rd_addr_bram  output  [AW-1:0] x N (unpacked): registered read address per bank.
REQ-009 rd_en_bram  output  [N-1:0]: registered read enable per bank.
REQ-010 out_valid  output  [N-1:0]: per-lane valid to the systolic array.
REQ-011 out_data  output  [D_W-1:0] x N (unpacked): per-lane data, meaningful only when the matching out_valid bit is 1.
REQ-012 busy  output  1: high from the cycle after an accepted start until done.
REQ-013 done  output  1: one-cycle pulse when the last word of the last lane has been presented.

Function
REQ-014 FSM states: IDLE, READ, DRAIN. IDLE->READ on start; READ->DRAIN after the last lane issues address D-1; DRAIN->IDLE after the last out_valid.
REQ-015 start is sampled only in IDLE; start while busy is ignored and SHALL NOT restart or extend the transfer.
REQ-016 With start accepted at cycle t, lane x SHALL assert rd_en_bram[x] with rd_addr_bram[x]=k at cycle t+1+S(x)+k for k=0..D-1 (S(x) defined in Configuration).
REQ-017 Each lane issues exactly D reads with consecutive addresses 0..D-1, no gaps and no repeats; the address SHALL return to 0 after D-1, never reaching D.
REQ-018 out_valid[x] SHALL be rd_en_bram[x] delayed by exactly one cycle (BRAM read latency 1).
REQ-019 out_data[x] SHALL equal rd_data_bram[x] combinationally (no extra register).
REQ-020 done SHALL pulse exactly one cycle after the final out_valid of lane N-1, in the same cycle busy falls; a start in that cycle is ignored; a start in the next cycle (IDLE) is accepted.
REQ-021 busy SHALL be 1 in READ and DRAIN and 0 in IDLE.
REQ-022 No backpressure: once started, the transfer runs to completion unless reset.

Reset
REQ-023 On rst=1 at a clock edge: FSM->IDLE; rd_en_bram, out_valid, busy, done = 0; every rd_addr_bram[x] = 0.
REQ-024 Reset mid-transfer SHALL abort immediately: no further rd_en or out_valid, and no done pulse for the aborted transfer.
REQ-025 rst takes priority over start in the same cycle.

Configuration
REQ-026 Macro MEM_READ_SKEW_EN: when defined, S(x) = x, so lane x lags lane 0 by x cycles (diagonal wavefront for the systolic array).
REQ-027 Without MEM_READ_SKEW_EN, S(x) = 0 and all lanes read in lockstep; the DRAIN length shrinks to match.

Verification (N=3, M=6, D=12, AW=4; bank x preloaded with word value 16*x+k at address k)
REQ-028 SKEW_EN: start at cycle 0 -> lane0 rd_en cycles 1..12, lane2 rd_en cycles 3..14; out_valid[2] cycles 4..15 with data 32..43; done=1 only at cycle 16.
REQ-029 No SKEW_EN: start at cycle 0 -> all lanes rd_en cycles 1..12, out_valid cycles 2..13, done at cycle 14.
REQ-030 start re-pulsed at cycles 5 and 16 during a cycle-0 transfer (SKEW_EN) -> timing identical to REQ-028; a start at cycle 17 begins a new transfer with lane0 rd_en at cycle 18.
REQ-031 rst asserted at cycle 7 of a transfer -> from cycle 8 all outputs 0 and addresses 0, no done; a start at cycle 9 gives a full fresh transfer from address 0.
REQ-032 rst and start together in IDLE -> start ignored; busy stays 0.
REQ-033 Back-to-back transfers -> every lane address sequence is 0..11 twice; address never equals 12.
